// File: rtl/mesh_ctrl_pkg.sv
// Shared types for the mesh traffic sequencer: FSM states, request packet
// layout and the data pattern written to and expected back from every word.
package mesh_ctrl_pkg;

   localparam int err_count_width_lp = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STORE  = 3'd1,
      WAIT_S = 3'd2,
      LOAD   = 3'd3,
      DRAIN  = 3'd4,
      DONE   = 3'd5
   } state_e;

   // Fields are sized for the widest supported coordinates; ports take the low bits.
   typedef struct packed {
      logic        store;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] addr;
      logic [31:0] data;
      logic [15:0] load_id;
   } pkt_t;

   function automatic logic [31:0] expected_data(input logic [7:0]  x,
                                                 input logic [7:0]  y,
                                                 input logic [15:0] word);
      return {x, y, word};
   endfunction

endpackage

// File: rtl/mesh_credit_counter.sv
// Outstanding-request credit counter: increments on issue, decrements on
// response, saturates at max_p and flags a decrement arriving at zero.
module mesh_credit_counter #(
   parameter int max_p   = 4,
   parameter int width_p = $clog2(max_p + 1)
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               inc_i,
   input  logic               dec_i,
   output logic [width_p-1:0] count_o,
   output logic               full_o,
   output logic               spurious_o
);

   logic [width_p-1:0] count_q, count_d;
   logic               inc_ok, dec_ok;

   // full_o reflects the count after this cycle's update, so a registered
   // request valid can be computed from it without a bubble.
   always_comb begin
      spurious_o = dec_i && (count_q == '0);
      inc_ok     = inc_i && (count_q != width_p'(max_p));
      dec_ok     = dec_i && (count_q != '0);
      count_d    = count_q;
      if (inc_ok && !dec_ok) begin
         count_d = count_q + width_p'(1);
      end else if (dec_ok && !inc_ok) begin
         count_d = count_q - width_p'(1);
      end
      full_o = (count_d == width_p'(max_p));
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mesh_traffic_ctrl.sv
// Store-then-load self-checking traffic sequencer for one mesh injection port.
// Every word of every tile is written, read back and compared.
module mesh_traffic_ctrl
   import mesh_ctrl_pkg::*;
#(
   parameter int x_cord_width_p  = 2,
   parameter int y_cord_width_p  = 2,
   parameter int data_width_p    = 32,
   parameter int addr_width_p    = 10,
   parameter int load_id_width_p = 11,
   parameter int num_words_p     = 4,
   parameter int max_out_p       = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          start_i,
   output logic                          pkt_v_o,
   input  logic                          pkt_ready_i,
   output logic                          pkt_store_o,
   output logic [x_cord_width_p-1:0]     pkt_x_o,
   output logic [y_cord_width_p-1:0]     pkt_y_o,
   output logic [addr_width_p-1:0]       pkt_addr_o,
   output logic [data_width_p-1:0]       pkt_data_o,
   output logic [load_id_width_p-1:0]    pkt_load_id_o,
   input  logic                          resp_v_i,
   input  logic                          resp_load_i,
   input  logic [data_width_p-1:0]       resp_data_i,
   input  logic [load_id_width_p-1:0]    resp_load_id_i,
   output logic                          finish_o,
   output logic                          error_o,
   output logic [err_count_width_lp-1:0] err_count_o,
   output logic [2:0]                    dbg_state_o
);

   localparam int word_width_lp = $clog2(num_words_p);
   localparam int cur_width_lp  = x_cord_width_p + y_cord_width_p + word_width_lp;
   localparam int cnt_width_lp  = $clog2(max_out_p + 1);

   state_e                        state_q, state_d;
   logic [cur_width_lp-1:0]       cur_q, cur_d;
   logic                          pkt_v_q, pkt_v_d;
   pkt_t                          pkt_q, pkt_d;
   logic                          finish_q, finish_d;
   logic                          error_q, error_d;
   logic [err_count_width_lp-1:0] err_cnt_q, err_cnt_d;

   logic                          hs, hold, issue_st, last_req;
   logic [cnt_width_lp-1:0]       out_cnt;
   logic                          cnt_full, spurious;
   logic [x_cord_width_p-1:0]     cur_x, rid_x;
   logic [y_cord_width_p-1:0]     cur_y, rid_y;
   logic [word_width_lp-1:0]      cur_w, rid_w;
   logic [cur_width_lp-1:0]       rid;
   logic                          wrong_kind, mismatch, err_evt;
   logic                          unused_pkt_hi;

   // Request handshake: a transfer happens in any cycle with pkt_v_o & pkt_ready_i;
   // once raised, valid and every pkt field hold until that cycle. Responses are
   // always accepted.
   assign hs       = pkt_v_q & pkt_ready_i;
   assign last_req = &cur_q;

   mesh_credit_counter #(
      .max_p   (max_out_p),
      .width_p (cnt_width_lp)
   ) u_credit (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .inc_i      (hs),
      .dec_i      (resp_v_i),
      .count_o    (out_cnt),
      .full_o     (cnt_full),
      .spurious_o (spurious)
   );

   // Cursor is {x, y, word}, so a plain increment walks x outer, word inner.
   assign {cur_x, cur_y, cur_w} = cur_d;
   assign rid                   = cur_width_lp'(resp_load_id_i);
   assign {rid_x, rid_y, rid_w} = rid;

   always_comb begin
      state_d = state_q;
      cur_d   = hs ? cur_q + cur_width_lp'(1) : cur_q;
      case (state_q)
         IDLE:    if (start_i) state_d = STORE;
         STORE:   if (hs && last_req) state_d = WAIT_S;
         WAIT_S:  if (out_cnt == '0) state_d = LOAD;
         LOAD:    if (hs && last_req) state_d = DRAIN;
         DRAIN:   if (out_cnt == '0) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hold     = pkt_v_q & ~pkt_ready_i;
      issue_st = (state_d == STORE) || (state_d == LOAD);
      pkt_v_d  = hold | (issue_st & ~cnt_full);
      pkt_d    = '0;
      if (hold) begin
         pkt_d = pkt_q;
      end else if (pkt_v_d) begin
         pkt_d.store   = (state_d == STORE);
         pkt_d.x       = 8'(cur_x);
         pkt_d.y       = 8'(cur_y);
         pkt_d.addr    = 16'(cur_w);
         pkt_d.data    = (state_d == STORE) ? expected_data(8'(cur_x), 8'(cur_y), 16'(cur_w)) : '0;
         pkt_d.load_id = 16'(cur_d);
      end
   end

   assign wrong_kind = resp_load_i ? ((state_q == STORE) || (state_q == WAIT_S))
                                   : ((state_q == LOAD)  || (state_q == DRAIN));
   assign mismatch   = resp_load_i &&
                       (resp_data_i != data_width_p'(expected_data(8'(rid_x), 8'(rid_y), 16'(rid_w))));
   assign err_evt    = resp_v_i & (spurious | wrong_kind | mismatch);
   assign err_cnt_d  = (err_evt && (err_cnt_q != '1)) ? err_cnt_q + err_count_width_lp'(1) : err_cnt_q;
   assign error_d    = error_q | err_evt;
   assign finish_d   = (state_d == DONE);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         cur_q     <= '0;
         pkt_v_q   <= 1'b0;
         pkt_q     <= '0;
         finish_q  <= 1'b0;
         error_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         pkt_v_q   <= pkt_v_d;
         pkt_q     <= pkt_d;
         finish_q  <= finish_d;
         error_q   <= error_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pkt_v_o       = pkt_v_q;
   assign pkt_store_o   = pkt_q.store;
   assign pkt_x_o       = pkt_q.x[x_cord_width_p-1:0];
   assign pkt_y_o       = pkt_q.y[y_cord_width_p-1:0];
   assign pkt_addr_o    = pkt_q.addr[addr_width_p-1:0];
   assign pkt_data_o    = pkt_q.data[data_width_p-1:0];
   assign pkt_load_id_o = pkt_q.load_id[load_id_width_p-1:0];
   assign finish_o      = finish_q;
   assign error_o       = error_q;
   assign err_count_o   = err_cnt_q;
   assign dbg_state_o   = state_q;

   // Upper packet bits beyond the configured widths are always zero.
   assign unused_pkt_hi = ^{pkt_q.x >> x_cord_width_p, pkt_q.y >> y_cord_width_p,
                            pkt_q.addr >> addr_width_p, pkt_q.data >> data_width_p,
                            pkt_q.load_id >> load_id_width_p};

endmodule
